// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// One requester's data-memory access port. Both the core execute stage and the
// host/loader use this same bundle.
//
//   req    requester -> arbiter  access request, level, held until gnt is seen
//   we     requester -> arbiter  1 = write, 0 = read
//   addr   requester -> arbiter  word address (AW bits)
//   wdata  requester -> arbiter  write data (DW bits)
//   gnt    arbiter -> requester  one-cycle pulse in the cycle the access runs
//   rvalid arbiter -> requester  one-cycle pulse the cycle after a read grant
//   rdata  arbiter -> requester  read data, meaningful while rvalid is high
//
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Owns the 2**AW x DW processor data memory and shares its single port between
// the core execute stage and an external host/loader. A two-state sequencer
// (IDLE -> ACCESS -> IDLE) picks one requester per access with round-robin
// arbitration, so the sustained rate is one access every two cycles.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   rst        asynchronous active-low reset (clears control state, not memory)
//   host_lock  only with DMEM_HOST_LOCK_EN: host requests exclusive ownership
//   core       slave side of dmem_arbiter_if for the core execute stage
//   host       slave side of dmem_arbiter_if for the host/loader
//   busy       high during the ACCESS cycle
//
// Optional build macro DMEM_HOST_LOCK_EN: a host grant taken with host_lock=1
// blocks all core grants until a host access with host_lock=0 completes.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef DMEM_HOST_LOCK_EN
    input  logic                 host_lock,
`endif
    dmem_arbiter_if.slave        core,
    dmem_arbiter_if.slave        host,
    output logic                 busy
);

    typedef enum logic { IDLE, ACCESS } state_t;
    typedef enum logic { OWN_CORE, OWN_HOST } owner_t;

    localparam int DEPTH = 1 << AW;

    state_t        state_reg, state_next;
    owner_t        owner_reg, owner_next;
    owner_t        last_reg;
    logic          start;
    logic          core_ok;

    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;

    logic          core_gnt_reg, host_gnt_reg;
    logic          core_rvalid_reg, host_rvalid_reg;
    logic [DW-1:0] core_rdata_reg, host_rdata_reg;

    logic [DW-1:0] mem [0:DEPTH-1];

`ifdef DMEM_HOST_LOCK_EN
    logic          lock_reg;
    logic          lock_latched_reg;
`endif

    // -------------------------------------------------------------------------
    // Next-state / arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        start      = 1'b0;
`ifdef DMEM_HOST_LOCK_EN
        // While the host holds the lock the core is simply not a candidate.
        core_ok    = core.req && !lock_reg;
`else
        core_ok    = core.req;
`endif
        case (state_reg)
            IDLE: begin
                if (core_ok && host.req) begin
                    start      = 1'b1;
                    // Tie: the requester that did not own the previous access wins.
                    owner_next = (last_reg == OWN_HOST) ? OWN_CORE : OWN_HOST;
                end else if (core_ok) begin
                    start      = 1'b1;
                    owner_next = OWN_CORE;
                end else if (host.req) begin
                    start      = 1'b1;
                    owner_next = OWN_HOST;
                end
                if (start) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // Requests are ignored here; always a single-cycle access.
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control state, request latch, grant/return registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            owner_reg        <= OWN_CORE;
            last_reg         <= OWN_HOST;   // core wins the first tie
            we_reg           <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            core_gnt_reg     <= 1'b0;
            host_gnt_reg     <= 1'b0;
            core_rvalid_reg  <= 1'b0;
            host_rvalid_reg  <= 1'b0;
            core_rdata_reg   <= '0;
            host_rdata_reg   <= '0;
`ifdef DMEM_HOST_LOCK_EN
            lock_reg         <= 1'b0;
            lock_latched_reg <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            // Grants are raised on the edge that enters ACCESS, so they line
            // up exactly with the ACCESS cycle.
            core_gnt_reg    <= start && (owner_next == OWN_CORE);
            host_gnt_reg    <= start && (owner_next == OWN_HOST);
            core_rvalid_reg <= 1'b0;
            host_rvalid_reg <= 1'b0;

            if (start) begin
                if (owner_next == OWN_CORE) begin
                    we_reg    <= core.we;
                    addr_reg  <= core.addr;
                    wdata_reg <= core.wdata;
                end else begin
                    we_reg    <= host.we;
                    addr_reg  <= host.addr;
                    wdata_reg <= host.wdata;
                end
`ifdef DMEM_HOST_LOCK_EN
                if (owner_next == OWN_HOST) begin
                    lock_latched_reg <= host_lock;
                    if (host_lock) begin
                        lock_reg <= 1'b1;
                    end
                end
`endif
            end

            if (state_reg == ACCESS) begin
                last_reg <= owner_reg;
                if (!we_reg) begin
                    if (owner_reg == OWN_CORE) begin
                        core_rdata_reg  <= mem[addr_reg];
                        core_rvalid_reg <= 1'b1;
                    end else begin
                        host_rdata_reg  <= mem[addr_reg];
                        host_rvalid_reg <= 1'b1;
                    end
                end
`ifdef DMEM_HOST_LOCK_EN
                if (owner_reg == OWN_HOST && !lock_latched_reg) begin
                    lock_reg <= 1'b0;
                end
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Memory array: never reset. An async reset forces state_reg to IDLE
    // before the closing edge, so an interrupted write is dropped.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_reg == ACCESS && we_reg) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

    assign busy        = (state_reg == ACCESS);
    assign core.gnt    = core_gnt_reg;
    assign host.gnt    = host_gnt_reg;
    assign core.rvalid = core_rvalid_reg;
    assign host.rvalid = host_rvalid_reg;
    assign core.rdata  = core_rdata_reg;
    assign host.rdata  = host_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed stimulus for dmem_arbiter. Stimulus pushes expected grant owners and
// expected read data into queues; a negedge monitor pops and compares whenever
// a gnt or rvalid appears.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    logic busy;
`ifdef DMEM_HOST_LOCK_EN
    logic host_lock;
`endif

    dmem_arbiter_if #(.AW(4), .DW(16)) core_if ();
    dmem_arbiter_if #(.AW(4), .DW(16)) host_if ();

    dmem_arbiter #(.AW(4), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DMEM_HOST_LOCK_EN
        .host_lock (host_lock),
`endif
        .core      (core_if),
        .host      (host_if),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit          exp_gnt_q[$];   // 0 = core, 1 = host
    logic [15:0] exp_core_q[$];
    logic [15:0] exp_host_q[$];

    bit  prev_core_gnt = 1'b0;
    bit  prev_host_gnt = 1'b0;
    time core_gnt_t    = 0;
    time host_gnt_t    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (core_if.gnt || host_if.gnt) begin
            checks++;
            if (core_if.gnt && host_if.gnt) begin
                failures++;
                $display("FAIL gnt_both: got core=1 host=1 expected one-hot");
            end else if (exp_gnt_q.size() == 0) begin
                failures++;
                $display("FAIL gnt_unexpected: got core=%0b host=%0b expected none", core_if.gnt, host_if.gnt);
            end else begin
                bit e;
                e = exp_gnt_q.pop_front();
                if (host_if.gnt != e) begin
                    failures++;
                    $display("FAIL gnt_owner: got host=%0b expected host=%0b", host_if.gnt, e);
                end
            end
            chk("busy_with_gnt", {31'b0, busy}, 32'd1);
            if (core_if.gnt) core_gnt_t = $time;
            if (host_if.gnt) host_gnt_t = $time;
            $display("[%0t] gnt core=%0b host=%0b", $time, core_if.gnt, host_if.gnt);
        end
        if (core_if.rvalid) begin
            checks++;
            if (exp_core_q.size() == 0) begin
                failures++;
                $display("FAIL core_rvalid_unexpected: got rdata=%0h expected no rvalid", core_if.rdata);
            end else begin
                logic [15:0] e;
                e = exp_core_q.pop_front();
                if (core_if.rdata !== e) begin
                    failures++;
                    $display("FAIL core_rdata: got %0h expected %0h", core_if.rdata, e);
                end
            end
            chk("core_rvalid_latency", {31'b0, prev_core_gnt}, 32'd1);
            $display("[%0t] core read rdata=%0h", $time, core_if.rdata);
        end
        if (host_if.rvalid) begin
            checks++;
            if (exp_host_q.size() == 0) begin
                failures++;
                $display("FAIL host_rvalid_unexpected: got rdata=%0h expected no rvalid", host_if.rdata);
            end else begin
                logic [15:0] e;
                e = exp_host_q.pop_front();
                if (host_if.rdata !== e) begin
                    failures++;
                    $display("FAIL host_rdata: got %0h expected %0h", host_if.rdata, e);
                end
            end
            chk("host_rvalid_latency", {31'b0, prev_host_gnt}, 32'd1);
            $display("[%0t] host read rdata=%0h", $time, host_if.rdata);
        end
        prev_core_gnt = core_if.gnt;
        prev_host_gnt = host_if.gnt;
    end

    // ------------------------------------------------------------------------
    // One access: raise req, wait (bounded) for gnt, drop req after the
    // closing edge. Grant order is pushed by the caller.
    // ------------------------------------------------------------------------
    task automatic access(input bit is_host, input logic we, input logic [3:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rd);
        int  n;
        bit  g;
        if (!we) begin
            if (is_host) exp_host_q.push_back(exp_rd);
            else         exp_core_q.push_back(exp_rd);
        end
        if (is_host) begin
            host_if.req = 1'b1; host_if.we = we; host_if.addr = a; host_if.wdata = d;
        end else begin
            core_if.req = 1'b1; core_if.we = we; core_if.addr = a; core_if.wdata = d;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            g = is_host ? host_if.gnt : core_if.gnt;
        end while (!g && n < 20);
        checks++;
        if (!g) begin
            failures++;
            $display("FAIL gnt_timeout: got no gnt in %0d cycles expected gnt (host=%0b)", n, is_host);
        end
        @(posedge clk); #1;
        if (is_host) host_if.req = 1'b0;
        else         core_if.req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gcount, core_g, host_g, n, phase, blocked;

        rst = 1'b0;
        core_if.req = 1'b0; core_if.we = 1'b0; core_if.addr = '0; core_if.wdata = '0;
        host_if.req = 1'b0; host_if.we = 1'b0; host_if.addr = '0; host_if.wdata = '0;
`ifdef DMEM_HOST_LOCK_EN
        host_lock = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_core_gnt",    {31'b0, core_if.gnt},    32'd0);
        chk("rst_host_gnt",    {31'b0, host_if.gnt},    32'd0);
        chk("rst_core_rvalid", {31'b0, core_if.rvalid}, 32'd0);
        chk("rst_busy",        {31'b0, busy},           32'd0);
        chk("rst_core_rdata",  {16'b0, core_if.rdata},  32'd0);
        chk("rst_host_rdata",  {16'b0, host_if.rdata},  32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Simultaneous writes right after reset: core wins the first tie.
        exp_gnt_q.push_back(1'b0);
        exp_gnt_q.push_back(1'b1);
        fork
            access(1'b0, 1'b1, 4'd1, 16'h0011, 16'h0);
            access(1'b1, 1'b1, 4'd2, 16'h0022, 16'h0);
        join
        exp_gnt_q.push_back(1'b0);
        access(1'b0, 1'b0, 4'd1, 16'h0, 16'h0011);
        exp_gnt_q.push_back(1'b1);
        access(1'b1, 1'b0, 4'd2, 16'h0, 16'h0022);

        // Core write then read-back.
        exp_gnt_q.push_back(1'b0);
        access(1'b0, 1'b1, 4'd3, 16'hA5A5, 16'h0);
        exp_gnt_q.push_back(1'b0);
        access(1'b0, 1'b0, 4'd3, 16'h0, 16'hA5A5);

        // Host write/read of the top address; core must see no rvalid.
        exp_gnt_q.push_back(1'b1);
        access(1'b1, 1'b1, 4'd15, 16'hFFFF, 16'h0);
        exp_gnt_q.push_back(1'b1);
        access(1'b1, 1'b0, 4'd15, 16'h0, 16'hFFFF);

        // Both requesters held for 8 accesses; last owner was host, so core first.
        for (int i = 0; i < 4; i++) begin
            exp_gnt_q.push_back(1'b0);
            exp_gnt_q.push_back(1'b1);
            exp_core_q.push_back(16'hA5A5);
            exp_host_q.push_back(16'hFFFF);
        end
        core_if.req = 1'b1; core_if.we = 1'b0; core_if.addr = 4'd3;
        host_if.req = 1'b1; host_if.we = 1'b0; host_if.addr = 4'd15;
        gcount = 0; core_g = 0; host_g = 0; n = 0; phase = 0;
        while (gcount < 8 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (core_if.gnt) core_g++;
            if (host_if.gnt) host_g++;
            if (core_if.gnt || host_if.gnt) gcount++;
            if (gcount > 0) begin
                chk("busy_toggle", {31'b0, busy}, (phase == 0) ? 32'd1 : 32'd0);
                phase ^= 1;
            end
        end
        chk("rr_total_grants", gcount, 32'd8);
        chk("rr_core_grants",  core_g, 32'd4);
        chk("rr_host_grants",  host_g, 32'd4);
        @(posedge clk); #1;
        core_if.req = 1'b0;
        host_if.req = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a core write: the write must be dropped.
        exp_gnt_q.push_back(1'b0);
        access(1'b0, 1'b1, 4'd5, 16'h0000, 16'h0);
        core_if.req = 1'b1; core_if.we = 1'b1; core_if.addr = 4'd5; core_if.wdata = 16'h1234;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!core_if.gnt && n < 20);
        chk("abort_gnt_seen", {31'b0, core_if.gnt}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("abort_gnt",    {31'b0, core_if.gnt},    32'd0);
        chk("abort_busy",   {31'b0, busy},           32'd0);
        chk("abort_rvalid", {31'b0, core_if.rvalid}, 32'd0);
        chk("abort_rdata",  {16'b0, core_if.rdata},  32'd0);
        core_if.req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_gnt_q.push_back(1'b0);
        access(1'b0, 1'b0, 4'd5, 16'h0, 16'h0000);

`ifdef DMEM_HOST_LOCK_EN
        // Host takes the lock; core request held must be starved until the
        // host releases it, then granted within two cycles.
        host_lock = 1'b1;
        exp_gnt_q.push_back(1'b1);
        access(1'b1, 1'b1, 4'd7, 16'h7777, 16'h0);
        host_lock = 1'b0;
        core_if.req = 1'b1; core_if.we = 1'b1; core_if.addr = 4'd9; core_if.wdata = 16'h9999;
        blocked = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (core_if.gnt) blocked++;
        end
        chk("lock_blocks_core", blocked, 32'd0);
        exp_gnt_q.push_back(1'b1);
        exp_gnt_q.push_back(1'b0);
        fork
            access(1'b0, 1'b1, 4'd9, 16'h9999, 16'h0);
            access(1'b1, 1'b1, 4'd8, 16'h8888, 16'h0);
        join
        chk("unlock_core_after_host", {31'b0, core_gnt_t > host_gnt_t}, 32'd1);
        chk("unlock_latency", 32'(core_gnt_t - host_gnt_t), 32'd20);
        exp_gnt_q.push_back(1'b0);
        access(1'b0, 1'b0, 4'd7, 16'h0, 16'h7777);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("gnt_queue_empty",  exp_gnt_q.size(),  32'd0);
        chk("core_queue_empty", exp_core_q.size(), 32'd0);
        chk("host_queue_empty", exp_host_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
